hazard_flush_ctrl: RTL and testbench

- Pipeline hazard controller for the 32-bit PA-RISC pipeline.
- Drives the flush select (S) of the ID-stage control-unit mux, the PC/nPC/IF-ID load enables and the operand-forwarding selects.
- Sequences load-use stalls, taken-branch delay-slot nullification and memory-busy freezes through a small FSM with a stall counter.
- Sits beside the decoder in the ID stage and observes EX/MEM/WB destination info.

---
 rtl/hazard_pkg.sv | 26 ++
 rtl/fwd_select.sv | 32 +++
 rtl/hazard_flush_ctrl.sv | 171 +++++++++++++++++
 tb/tb_hazard_flush_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the ID-stage hazard controller: FSM states, forwarding
// select encodings and the forwarding priority helper.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FREEZE   = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  // Youngest producer wins: a later stage holds an older, stale value.
  function automatic logic [1:0] fwd_priority(input logic ex_hit,
                                              input logic mem_hit,
                                              input logic wb_hit);
    if (ex_hit)       return FWD_EX;
    else if (mem_hit) return FWD_MEM;
    else if (wb_hit)  return FWD_WB;
    else              return FWD_RF;
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding compare: matches one ID source register against the
// EX/MEM/WB destinations and picks the operand source.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic              i_use,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_rf_le,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic              i_mem_rf_le,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic              i_wb_rf_le,
  output logic [1:0]        o_sel,
  output logic              o_ex_hit
);

  logic w_valid_src;
  logic w_mem_hit;
  logic w_wb_hit;

  // r0 is hardwired zero, so it is never a real dependency.
  assign w_valid_src = i_use & (i_src != '0);
  assign o_ex_hit    = w_valid_src & i_ex_rf_le  & (i_ex_rd  == i_src);
  assign w_mem_hit   = w_valid_src & i_mem_rf_le & (i_mem_rd == i_src);
  assign w_wb_hit    = w_valid_src & i_wb_rf_le  & (i_wb_rd  == i_src);

  assign o_sel = fwd_priority(o_ex_hit, w_mem_hit, w_wb_hit);

endmodule

// File: rtl/hazard_flush_ctrl.sv
// ID-stage hazard controller: forwarding selects, load-use bubbles, branch
// delay-slot nullification and memory-busy freeze. Optional HAZ_PERF_CNT_EN
// adds saturating event counters.
module hazard_flush_ctrl
  import hazard_pkg::*;
#(
  parameter int LU_STALL_CYCLES = 1,
  parameter int REG_AW          = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_ra,
  input  logic [REG_AW-1:0] id_rb,
  input  logic              id_use_ra,
  input  logic              id_use_rb,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_rf_le,
  input  logic              ex_l,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_rf_le,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_rf_le,
  input  logic              br_taken,
  input  logic              br_nullify,
  input  logic              mem_busy,
  output logic              cu_mux_s,
  output logic              pc_le,
  output logic              npc_le,
  output logic              if_id_le,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [2:0]        stall_cnt
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]       perf_lu_stalls,
  output logic [31:0]       perf_br_flushes,
  output logic [31:0]       perf_freeze_cycles
`endif
);

  localparam logic [2:0] LU_INIT = 3'(LU_STALL_CYCLES - 1);

  state_t     r_state;
  state_t     r_saved;
  state_t     w_next_state;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_next;
  logic       w_flush;
  logic       w_le;
  logic       w_load_use;
  logic       w_ex_hit_a;
  logic       w_ex_hit_b;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .i_src      (id_ra),
    .i_use      (id_use_ra),
    .i_ex_rd    (ex_rd),
    .i_ex_rf_le (ex_rf_le),
    .i_mem_rd   (mem_rd),
    .i_mem_rf_le(mem_rf_le),
    .i_wb_rd    (wb_rd),
    .i_wb_rf_le (wb_rf_le),
    .o_sel      (w_fwd_a),
    .o_ex_hit   (w_ex_hit_a)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .i_src      (id_rb),
    .i_use      (id_use_rb),
    .i_ex_rd    (ex_rd),
    .i_ex_rf_le (ex_rf_le),
    .i_mem_rd   (mem_rd),
    .i_mem_rf_le(mem_rf_le),
    .i_wb_rd    (wb_rd),
    .i_wb_rf_le (wb_rf_le),
    .o_sel      (w_fwd_b),
    .o_ex_hit   (w_ex_hit_b)
  );

  // A load in EX cannot forward: its data only exists after MEM.
  assign w_load_use = ex_l & (w_ex_hit_a | w_ex_hit_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_saved <= RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
      if (mem_busy && (r_state != FREEZE)) r_saved <= r_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_flush      = 1'b0;
    w_le         = 1'b1;
    if (mem_busy) begin
      w_next_state = FREEZE;
      w_le         = 1'b0;
    end else begin
      case (r_state)
        FREEZE: begin
          w_le         = 1'b0;
          w_next_state = r_saved;
        end
        LU_STALL: begin
          if (br_taken) begin
            w_flush      = br_nullify;
            w_next_state = RUN;
            w_cnt_next   = 3'd0;
          end else begin
            w_flush    = 1'b1;
            w_le       = 1'b0;
            w_cnt_next = r_cnt - 3'd1;
            if (r_cnt <= 3'd1) w_next_state = RUN;
          end
        end
        default: begin
          w_next_state = RUN;
          if (br_taken) begin
            w_flush = br_nullify;
          end else if (w_load_use) begin
            w_flush      = 1'b1;
            w_le         = 1'b0;
            w_cnt_next   = LU_INIT;
            w_next_state = (LU_INIT != 3'd0) ? LU_STALL : RUN;
          end
        end
      endcase
    end
  end

  // Reset forces a bubble into the control path independent of FSM state.
  assign cu_mux_s  = ~rst_n | w_flush;
  assign pc_le     = rst_n & w_le;
  assign npc_le    = rst_n & w_le;
  assign if_id_le  = rst_n & w_le;
  assign fwd_a     = rst_n ? w_fwd_a : FWD_RF;
  assign fwd_b     = rst_n ? w_fwd_b : FWD_RF;
  assign stall_cnt = r_cnt;

`ifdef HAZ_PERF_CNT_EN
  logic w_perf_lu;
  logic w_perf_br;

  // Bubble with frozen fetch is a load-use stall; bubble with fetch is a kill.
  assign w_perf_lu = w_flush & ~w_le;
  assign w_perf_br = w_flush & w_le;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lu_stalls     <= 32'd0;
      perf_br_flushes    <= 32'd0;
      perf_freeze_cycles <= 32'd0;
    end else begin
      if (w_perf_lu && (perf_lu_stalls != '1))
        perf_lu_stalls <= perf_lu_stalls + 32'd1;
      if (w_perf_br && (perf_br_flushes != '1))
        perf_br_flushes <= perf_br_flushes + 32'd1;
      if (mem_busy && (perf_freeze_cycles != '1))
        perf_freeze_cycles <= perf_freeze_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Self-checking bench for hazard_flush_ctrl: directed scenarios plus random
// traffic against a "bubbles owed" reference model.
module tb_hazard_flush_ctrl;

  localparam int LU = 3;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] id_ra, id_rb, ex_rd, mem_rd, wb_rd;
  logic          id_use_ra, id_use_rb, ex_rf_le, ex_l, mem_rf_le, wb_rf_le;
  logic          br_taken, br_nullify, mem_busy;
  logic          cu_mux_s, pc_le, npc_le, if_id_le;
  logic [1:0]    fwd_a, fwd_b;
  logic [2:0]    stall_cnt;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]   perf_lu_stalls, perf_br_flushes, perf_freeze_cycles;
`endif

  always #5 clk = ~clk;

  hazard_flush_ctrl #(.LU_STALL_CYCLES(LU), .REG_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_ra(id_ra), .id_rb(id_rb), .id_use_ra(id_use_ra), .id_use_rb(id_use_rb),
    .ex_rd(ex_rd), .ex_rf_le(ex_rf_le), .ex_l(ex_l),
    .mem_rd(mem_rd), .mem_rf_le(mem_rf_le), .wb_rd(wb_rd), .wb_rf_le(wb_rf_le),
    .br_taken(br_taken), .br_nullify(br_nullify), .mem_busy(mem_busy),
    .cu_mux_s(cu_mux_s), .pc_le(pc_le), .npc_le(npc_le), .if_id_le(if_id_le),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
`ifdef HAZ_PERF_CNT_EN
    , .perf_lu_stalls(perf_lu_stalls), .perf_br_flushes(perf_br_flushes),
    .perf_freeze_cycles(perf_freeze_cycles)
`endif
  );

  typedef struct {
    logic [AW-1:0] ra, rb, exRd, memRd, wbRd;
    logic          ua, ub, exLe, exL, memLe, wbLe, brT, brN, busy;
    logic [10:0]   want;
  } step_t;

  int          checks = 0;
  int          errors = 0;
  int          pending;
  bit          holdTail;
  int          nLu, nBr, nFrz;
  logic [10:0] expVec;

  // Observed vector layout: {cu_mux_s, pc_le, npc_le, if_id_le, fwd_a, fwd_b, stall_cnt}.
  function automatic logic [10:0] obsVec();
    return {cu_mux_s, pc_le, npc_le, if_id_le, fwd_a, fwd_b, stall_cnt};
  endfunction

  function automatic step_t mkStep(int ra, bit ua, int rb, bit ub, int exRd, bit exLe, bit exL,
                                   int memRd, bit memLe, int wbRd, bit wbLe, bit brT, bit brN,
                                   bit busy, logic [10:0] want);
    step_t s;
    s.ra = AW'(ra); s.ua = ua; s.rb = AW'(rb); s.ub = ub;
    s.exRd = AW'(exRd); s.exLe = exLe; s.exL = exL;
    s.memRd = AW'(memRd); s.memLe = memLe; s.wbRd = AW'(wbRd); s.wbLe = wbLe;
    s.brT = brT; s.brN = brN; s.busy = busy; s.want = want;
    return s;
  endfunction

  task automatic applyStimulus(input step_t s);
    id_ra = s.ra; id_use_ra = s.ua; id_rb = s.rb; id_use_rb = s.ub;
    ex_rd = s.exRd; ex_rf_le = s.exLe; ex_l = s.exL;
    mem_rd = s.memRd; mem_rf_le = s.memLe; wb_rd = s.wbRd; wb_rf_le = s.wbLe;
    br_taken = s.brT; br_nullify = s.brN; mem_busy = s.busy;
  endtask

  // Reference forwarding: the youngest stage writing the same nonzero register.
  function automatic logic [1:0] refFwd(logic [AW-1:0] src, logic used);
    if (!used || src == 0) return 2'b00;
    if (ex_rf_le && ex_rd == src) return 2'b01;
    if (mem_rf_le && mem_rd == src) return 2'b10;
    if (wb_rf_le && wb_rd == src) return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit refLoadUse();
    return ex_l && ex_rf_le &&
           ((id_use_ra && id_ra != 0 && id_ra == ex_rd) ||
            (id_use_rb && id_rb != 0 && id_rb == ex_rd));
  endfunction

  task automatic resetModel();
    pending = 0; holdTail = 0; nLu = 0; nBr = 0; nFrz = 0;
  endtask

  task automatic computeExpected();
    logic cu, le;
    if (!rst_n) begin
      expVec = 11'b1_000_00_00_000;
    end else begin
      if (mem_busy || holdTail)    begin cu = 1'b0;       le = 1'b0; end
      else if (br_taken)           begin cu = br_nullify; le = 1'b1; end
      else if (pending > 0 || refLoadUse()) begin cu = 1'b1; le = 1'b0; end
      else                         begin cu = 1'b0;       le = 1'b1; end
      expVec = {cu, le, le, le, refFwd(id_ra, id_use_ra), refFwd(id_rb, id_use_rb), 3'(pending)};
    end
  endtask

  // Advances the model by one clock using the inputs present at the edge.
  task automatic updateModel();
    if (!rst_n) begin
      resetModel();
    end else begin
      if (mem_busy) nFrz++;
      if (mem_busy || holdTail) begin
      end else if (br_taken) begin
        pending = 0;
        if (br_nullify) nBr++;
      end else if (pending > 0) begin
        pending--; nLu++;
      end else if (refLoadUse()) begin
        pending = LU - 1; nLu++;
      end
      holdTail = mem_busy;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic test_reset();
    step_t steps[$];
    rst_n = 1'b0;
    applyStimulus(mkStep(0,0,0,0,0,0,0,0,0,0,0,0,0,0,'0));
    resetModel();
    #12;
    checks++;
    if (obsVec() !== 11'b1_000_00_00_000) begin
      errors++; $display("[TB] FAIL reset_hold got %b want %b", obsVec(), 11'b1_000_00_00_000);
    end
    rst_n = 1'b1;
    advance();
    steps.push_back(mkStep(0,0,0,0,0,0,0,0,0,0,0,0,0,0, 11'b0_111_00_00_000));
    steps.push_back(mkStep(0,0,7,1,7,1,1,0,0,0,0,0,0,0, 11'b1_000_00_01_000));
    foreach (steps[i]) begin
      applyStimulus(steps[i]);
      @(negedge clk);
      checks++;
      if (obsVec() !== steps[i].want) begin
        errors++; $display("[TB] FAIL reset_pre[%0d] got %b want %b", i, obsVec(), steps[i].want);
      end
      advance();
    end
    applyStimulus(mkStep(0,0,0,0,0,0,0,0,0,0,0,0,0,0,'0));
    @(negedge clk);
    checks++;
    if (obsVec() !== 11'b1_000_00_00_010) begin
      errors++; $display("[TB] FAIL reset_stall2 got %b want %b", obsVec(), 11'b1_000_00_00_010);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obsVec() !== 11'b1_000_00_00_000) begin
      errors++; $display("[TB] FAIL reset_mid_stall got %b want %b", obsVec(), 11'b1_000_00_00_000);
    end
    resetModel();
    #1 rst_n = 1'b1;
    advance();
    @(negedge clk);
    checks++;
    if (obsVec() !== 11'b0_111_00_00_000) begin
      errors++; $display("[TB] FAIL reset_release got %b want %b", obsVec(), 11'b0_111_00_00_000);
    end
    advance();
  endtask

  task automatic test_forwarding();
    step_t steps[$];
    steps.push_back(mkStep(5,1,0,0,5,1,0,5,1,0,0,0,0,0, 11'b0_111_01_00_000));
    steps.push_back(mkStep(0,1,0,0,0,1,0,0,1,0,0,0,0,0, 11'b0_111_00_00_000));
    steps.push_back(mkStep(5,1,0,0,5,0,0,5,1,0,0,0,0,0, 11'b0_111_10_00_000));
    steps.push_back(mkStep(5,1,0,0,5,0,0,5,0,5,1,0,0,0, 11'b0_111_11_00_000));
    steps.push_back(mkStep(5,1,5,0,5,1,0,0,0,0,0,0,0,0, 11'b0_111_01_00_000));
    steps.push_back(mkStep(6,1,6,1,6,0,0,2,1,6,1,0,0,0, 11'b0_111_11_11_000));
    steps.push_back(mkStep(3,1,9,1,9,1,0,3,1,3,1,0,0,0, 11'b0_111_10_01_000));
    foreach (steps[i]) begin
      applyStimulus(steps[i]);
      @(negedge clk);
      checks++;
      if (obsVec() !== steps[i].want) begin
        errors++; $display("[TB] FAIL fwd[%0d] got %b want %b", i, obsVec(), steps[i].want);
      end
      advance();
    end
  endtask

  task automatic test_load_use();
    step_t steps[$];
    steps.push_back(mkStep(0,0,7,1,7,1,1,0,0,0,0,0,0,0, 11'b1_000_00_01_000));
    steps.push_back(mkStep(0,0,7,1,0,0,0,7,1,0,0,0,0,0, 11'b1_000_00_10_010));
    steps.push_back(mkStep(0,0,7,1,0,0,0,7,1,0,0,0,0,0, 11'b1_000_00_10_001));
    steps.push_back(mkStep(0,0,7,1,0,0,0,7,1,0,0,0,0,0, 11'b0_111_00_10_000));
    steps.push_back(mkStep(4,1,0,0,4,0,1,0,0,0,0,0,0,0, 11'b0_111_00_00_000));
    steps.push_back(mkStep(0,1,0,1,0,1,1,0,0,0,0,0,0,0, 11'b0_111_00_00_000));
    foreach (steps[i]) begin
      applyStimulus(steps[i]);
      @(negedge clk);
      checks++;
      if (obsVec() !== steps[i].want) begin
        errors++; $display("[TB] FAIL load_use[%0d] got %b want %b", i, obsVec(), steps[i].want);
      end
      advance();
    end
  endtask

  task automatic test_branch();
    step_t steps[$];
    steps.push_back(mkStep(0,0,7,1,7,1,1,0,0,0,0,1,1,0, 11'b1_111_00_01_000));
    steps.push_back(mkStep(0,0,0,0,0,0,0,0,0,0,0,0,0,0, 11'b0_111_00_00_000));
    steps.push_back(mkStep(0,0,7,1,7,1,1,0,0,0,0,1,0,0, 11'b0_111_00_01_000));
    steps.push_back(mkStep(0,0,0,0,0,0,0,0,0,0,0,0,0,0, 11'b0_111_00_00_000));
    steps.push_back(mkStep(0,0,7,1,7,1,1,0,0,0,0,0,0,0, 11'b1_000_00_01_000));
    steps.push_back(mkStep(0,0,0,0,0,0,0,0,0,0,0,1,1,0, 11'b1_111_00_00_010));
    steps.push_back(mkStep(0,0,0,0,0,0,0,0,0,0,0,0,0,0, 11'b0_111_00_00_000));
    foreach (steps[i]) begin
      applyStimulus(steps[i]);
      @(negedge clk);
      checks++;
      if (obsVec() !== steps[i].want) begin
        errors++; $display("[TB] FAIL branch[%0d] got %b want %b", i, obsVec(), steps[i].want);
      end
      advance();
    end
  endtask

  task automatic test_freeze();
    step_t steps[$];
    steps.push_back(mkStep(0,0,7,1,7,1,1,0,0,0,0,0,0,0, 11'b1_000_00_01_000));
    steps.push_back(mkStep(0,0,0,0,0,0,0,0,0,0,0,0,0,0, 11'b1_000_00_00_010));
    for (int k = 0; k < 3; k++)
      steps.push_back(mkStep(0,0,0,0,0,0,0,0,0,0,0,0,0,1, 11'b0_000_00_00_001));
    steps.push_back(mkStep(0,0,0,0,0,0,0,0,0,0,0,0,0,0, 11'b0_000_00_00_001));
    steps.push_back(mkStep(0,0,0,0,0,0,0,0,0,0,0,0,0,0, 11'b1_000_00_00_001));
    steps.push_back(mkStep(0,0,0,0,0,0,0,0,0,0,0,0,0,0, 11'b0_111_00_00_000));
    steps.push_back(mkStep(0,0,0,0,0,0,0,0,0,0,0,1,1,1, 11'b0_000_00_00_000));
    steps.push_back(mkStep(0,0,0,0,0,0,0,0,0,0,0,0,0,0, 11'b0_000_00_00_000));
    steps.push_back(mkStep(0,0,0,0,0,0,0,0,0,0,0,0,0,0, 11'b0_111_00_00_000));
    foreach (steps[i]) begin
      applyStimulus(steps[i]);
      @(negedge clk);
      checks++;
      if (obsVec() !== steps[i].want) begin
        errors++; $display("[TB] FAIL freeze[%0d] got %b want %b", i, obsVec(), steps[i].want);
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      id_ra = AW'($urandom_range(0, 3));  id_use_ra = 1'($urandom_range(0, 1));
      id_rb = AW'($urandom_range(0, 3));  id_use_rb = 1'($urandom_range(0, 1));
      ex_rd = AW'($urandom_range(0, 3));  ex_rf_le = 1'($urandom_range(0, 1));
      ex_l = ($urandom_range(0, 2) == 0);
      mem_rd = AW'($urandom_range(0, 3)); mem_rf_le = 1'($urandom_range(0, 1));
      wb_rd = AW'($urandom_range(0, 3));  wb_rf_le = 1'($urandom_range(0, 1));
      br_taken = ($urandom_range(0, 7) == 0); br_nullify = 1'($urandom_range(0, 1));
      mem_busy = ($urandom_range(0, 9) == 0);
      computeExpected();
      @(negedge clk);
      checks++;
      if (obsVec() !== expVec) begin
        errors++; $display("[TB] FAIL random[%0d] got %b want %b", n, obsVec(), expVec);
      end
      advance();
    end
  endtask

`ifdef HAZ_PERF_CNT_EN
  task automatic test_perf();
    applyStimulus(mkStep(0,0,0,0,0,0,0,0,0,0,0,0,0,0,'0));
    @(negedge clk);
    checks++;
    if (perf_lu_stalls !== 32'(nLu)) begin
      errors++; $display("[TB] FAIL perf_lu got %0d want %0d", perf_lu_stalls, nLu);
    end
    checks++;
    if (perf_br_flushes !== 32'(nBr)) begin
      errors++; $display("[TB] FAIL perf_br got %0d want %0d", perf_br_flushes, nBr);
    end
    checks++;
    if (perf_freeze_cycles !== 32'(nFrz)) begin
      errors++; $display("[TB] FAIL perf_frz got %0d want %0d", perf_freeze_cycles, nFrz);
    end
    advance();
  endtask
`endif

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_freeze();
    test_random();
`ifdef HAZ_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] model events: bubbles=%0d kills=%0d busy=%0d", nLu, nBr, nFrz);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
